hash_display_core: RTL



---
 rtl/hash_display_core.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hash_display_core.sv
// hash_display_core: epoch tick, debounced display toggle, rolling hash and
// multi-cycle double-dabble BCD conversion, all on one clock domain.
module hash_display_core #(
    parameter int WIDTH      = 16,
    parameter int DIGITS     = 5,
    parameter int TICK_DIV   = 5000000,
    parameter int DEB_CYCLES = 2000,
    parameter int ROT        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button_in,
    input  logic [WIDTH-1:0]    student_id,
    output logic [WIDTH-1:0]    cur_time,
    output logic [WIDTH-1:0]    cur_hash,
    output logic                enable,
    output logic                busy,
    output logic                bcd_valid,
    output logic [4*DIGITS-1:0] digits
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    logic          sync0, sync1, deb_level;
    logic [DW-1:0] deb_cnt;
    logic          deb_flip;

    assign deb_flip = (sync1 != deb_level) &&
                      (deb_cnt == DW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            enable    <= 1'b0;
        end else begin
            sync0 <= button_in;
            sync1 <= sync0;
            if (sync1 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_flip) begin
                deb_cnt   <= '0;
                deb_level <= sync1;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
            if (deb_flip && sync1) enable <= ~enable;
        end
    end

    logic [WIDTH-1:0]   t_new, mix;
    logic [2*WIDTH-1:0] mix2;
    logic               start_req;

    assign t_new = cur_time + WIDTH'(1);
    assign mix   = cur_hash ^ (student_id + t_new);
    assign mix2  = {mix, mix};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_time  <= '0;
            cur_hash  <= '0;
            start_req <= 1'b0;
        end else begin
            start_req <= tick;
            if (tick) begin
                cur_time <= t_new;
                cur_hash <= mix2[2*WIDTH-1-ROT -: WIDTH];
            end
        end
    end

    logic [1:0]       state;
    logic [IW-1:0]    it_cnt;
    logic [WIDTH-1:0] bin_sr;
    logic [BW-1:0]    bcd_sr, bcd_adj, digit_reg;
    logic             pending, take;

    assign take = start_req || pending;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // DONE with work queued reloads straight into SHIFT so busy never drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            it_cnt    <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            digit_reg <= '0;
            pending   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        bin_sr  <= cur_hash;
                        bcd_sr  <= '0;
                        it_cnt  <= '0;
                        pending <= 1'b0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    it_cnt <= it_cnt + IW'(1);
                    if (start_req) pending <= 1'b1;
                    if (it_cnt == IW'(WIDTH - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    digit_reg <= bcd_sr;
                    if (take) begin
                        bin_sr  <= cur_hash;
                        bcd_sr  <= '0;
                        it_cnt  <= '0;
                        pending <= 1'b0;
                        state   <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign bcd_valid = (state == S_DONE);
    assign digits    = enable ? digit_reg : {BW{1'b1}};

endmodule
